mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/arb_timeout.sv | 30 +++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// FSM state encoding, requester identifiers and datapath widths.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10,
        RESP  = 2'b11
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

endpackage

// File: rtl/arb_timeout.sv
// Grant-age counter: cleared when a grant is issued, advanced on every granted
// cycle that has not completed, and flags the cycle on which the age limit is hit.
module arb_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);
    import mem_arbiter_pkg::*;

    logic [CNT_W-1:0] count_q;

    // Age register: restart on grant, count while the grant is still waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + 1'b1;
        end
    end

    // The LIMIT-th waiting cycle is the last one allowed.
    assign terminal = count_en && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (fetch side I, data side D) in front of a cached
// memory system. One transaction at a time: IDLE -> GNT_x -> RESP -> IDLE, with a
// grant-age abort that raises the sticky err flag.
// Build option: define MEM_ARBITER_RR_EN for round-robin on simultaneous I/D
// requests; otherwise D always wins over I.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    // Fetch requester
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    output logic        i_done,
    output logic [15:0] i_data,
    // Data requester
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    // Memory system
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    input  logic        mem_stall,
    // Status
    output logic        busy,
    output logic        err
);
    import mem_arbiter_pkg::*;

    arb_state_e state_q, state_d;
    req_id_e    gnt_q, gnt_d;
    logic       d_req, d_conflict, pick_d;
    logic       grant, in_gnt, tmo_en, tmo_hit, set_err;
    logic       err_q;
    logic       unused_stall;

    // Stall is purely informational; the arbiter simply keeps waiting for mem_done.
    assign unused_stall = mem_stall;

    // A D request is valid only when exactly one of read/write is asserted.
    assign d_req      = d_rd ^ d_wr;
    assign d_conflict = d_rd & d_wr;
    assign in_gnt     = (state_q == GNT_I) || (state_q == GNT_D);
    assign tmo_en     = in_gnt && !mem_done;
    assign grant      = (state_q == IDLE) && (state_d != IDLE);

`ifdef MEM_ARBITER_RR_EN
    req_id_e rr_q;

    // Round-robin pointer: after each completion favour the side not just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= REQ_D;
        end else if (state_q == RESP) begin
            rr_q <= (gnt_q == REQ_D) ? REQ_I : REQ_D;
        end
    end

    assign pick_d = (rr_q == REQ_D);
`else
    assign pick_d = 1'b1;
`endif

    arb_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (grant),
        .count_en (tmo_en),
        .terminal (tmo_hit)
    );

    // State and granted-side registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= REQ_I;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state: arbitration in IDLE, completion or abort in GNT, single RESP cycle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        set_err = 1'b0;
        case (state_q)
            IDLE: begin
                set_err = d_conflict;
                if (d_req && (pick_d || !i_rd)) begin
                    state_d = GNT_D;
                    gnt_d   = REQ_D;
                end else if (i_rd) begin
                    state_d = GNT_I;
                    gnt_d   = REQ_I;
                end
            end
            GNT_I, GNT_D: begin
                if (mem_done) begin
                    state_d = RESP;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    set_err = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory command registers and per-side read data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            i_data    <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant) begin
                if (gnt_d == REQ_D) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    mem_rd    <= d_rd;
                    mem_wr    <= d_wr;
                end else begin
                    mem_addr  <= i_addr;
                    mem_wdata <= '0;
                    mem_rd    <= 1'b1;
                    mem_wr    <= 1'b0;
                end
            end else if (in_gnt && (state_d != state_q)) begin
                // Leaving the grant on completion or abort drops the command.
                mem_rd <= 1'b0;
                mem_wr <= 1'b0;
            end
            if ((state_q == GNT_I) && mem_done) begin
                i_data <= mem_rdata;
            end
            if ((state_q == GNT_D) && mem_done) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    // Sticky error: D read/write conflict or grant timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end
    end

    assign err    = err_q;
    assign busy   = (state_q != IDLE);
    assign i_done = (state_q == RESP) && (gnt_q == REQ_I);
    assign d_done = (state_q == RESP) && (gnt_q == REQ_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected completions.
// Honours MEM_ARBITER_RR_EN for the back-to-back contention ordering.
module tb_mem_arbiter;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rd;
    logic [15:0] i_addr;
    logic        i_done;
    logic [15:0] i_data;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        busy;
    logic        err;

    typedef struct packed {
        logic        side;  // 1 = D, 0 = I
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_arbiter #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_rd      (i_rd),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_data    (i_data),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_stall (mem_stall),
        .busy      (busy),
        .err       (err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic side, input logic [15:0] data);
        exp_t e;
        e.side = side;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
        check({tag, "_i_data"}, 32'(i_data), 32'h0);
        check({tag, "_d_rdata"}, 32'(d_rdata), 32'h0);
        check({tag, "_i_done"}, 32'(i_done), 32'h0);
        check({tag, "_d_done"}, 32'(d_done), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    // Bounded wait for a memory command to appear.
    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (!(mem_rd || mem_wr) && n < 16) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_grant_seen"}, 32'(mem_rd || mem_wr), 32'h1);
        check({tag, "_busy_gnt"}, 32'(busy), 32'h1);
    endtask

    // Act as the memory: check the issued command, wait, then complete it.
    task automatic serve(input string tag, input logic [15:0] e_addr, input logic [15:0] e_wdata,
                         input logic e_wr, input int delay, input logic [15:0] rdata);
        wait_grant(tag);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(e_addr));
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'(!e_wr));
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'(e_wr));
        if (e_wr) check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(e_wdata));
        for (int k = 0; k < delay; k++) begin
            mem_stall = 1'b1;
            @(negedge clk);
            check({tag, "_addr_held"}, 32'(mem_addr), 32'(e_addr));
            check({tag, "_no_done_gnt"}, 32'({i_done, d_done}), 32'h0);
        end
        mem_stall = 1'b0;
        mem_rdata = rdata;
        mem_done  = 1'b1;
        @(negedge clk);
        mem_done  = 1'b0;
    endtask

    // At the RESP cycle: pop the scoreboard and compare done pulses and data.
    task automatic expect_done(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_busy_resp"}, 32'(busy), 32'h1);
            check({tag, "_i_done"}, 32'(i_done), 32'(!e.side));
            check({tag, "_d_done"}, 32'(d_done), 32'(e.side));
            check({tag, "_mem_cmd_low"}, 32'({mem_rd, mem_wr}), 32'h0);
            if (e.side) check({tag, "_d_rdata"}, 32'(d_rdata), 32'(e.data));
            else        check({tag, "_i_data"}, 32'(i_data), 32'(e.data));
        end
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'({i_done, d_done}), 32'h0);
        check({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        i_rd      = 1'b0;
        i_addr    = '0;
        d_rd      = 1'b0;
        d_wr      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_done  = 1'b0;
        mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_req", 32'({busy, mem_rd, mem_wr}), 32'h0);

        // Lone fetch, completion two cycles after grant.
        i_rd   = 1'b1;
        i_addr = 16'h0040;
        push_exp(1'b0, 16'h1234);
        serve("lone_i", 16'h0040, 16'h0000, 1'b0, 2, 16'h1234);
        expect_done("lone_i");
        i_rd = 1'b0;
        after_done("lone_i");

        // Simultaneous fetch and data write: D is served first.
        i_rd    = 1'b1;
        i_addr  = 16'h0200;
        d_wr    = 1'b1;
        d_addr  = 16'h0100;
        d_wdata = 16'hBEEF;
        push_exp(1'b1, 16'h0A0A);
        serve("cont1_d", 16'h0100, 16'hBEEF, 1'b1, 0, 16'h0A0A);
        expect_done("cont1_d");
        check("i_data_hold", 32'(i_data), 32'h1234);
        // New D read while the fetch is still pending.
        d_wr   = 1'b0;
        d_rd   = 1'b1;
        d_addr = 16'h0110;
`ifdef MEM_ARBITER_RR_EN
        push_exp(1'b0, 16'h2222);
        push_exp(1'b1, 16'h3333);
        serve("cont2_i", 16'h0200, 16'h0000, 1'b0, 1, 16'h2222);
        expect_done("cont2_i");
        i_rd = 1'b0;
        after_done("cont2_i");
        serve("cont2_d", 16'h0110, 16'h0000, 1'b0, 1, 16'h3333);
        expect_done("cont2_d");
        d_rd = 1'b0;
`else
        push_exp(1'b1, 16'h3333);
        push_exp(1'b0, 16'h2222);
        serve("cont2_d", 16'h0110, 16'h0000, 1'b0, 1, 16'h3333);
        expect_done("cont2_d");
        d_rd = 1'b0;
        after_done("cont2_d");
        serve("cont2_i", 16'h0200, 16'h0000, 1'b0, 1, 16'h2222);
        expect_done("cont2_i");
        i_rd = 1'b0;
`endif
        after_done("cont2");

        // Reset in the middle of a D write grant.
        d_wr    = 1'b1;
        d_addr  = 16'h0500;
        d_wdata = 16'h1111;
        wait_grant("rst_mid");
        check("rst_mid_mem_wr", 32'(mem_wr), 32'h1);
        #1 rst = 1'b1;
        #1 check_zero("rst_mid");
        d_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_after", 32'({busy, d_done}), 32'h0);

        // Grant that never completes: abort after TMO cycles.
        d_rd   = 1'b1;
        d_addr = 16'h0300;
        wait_grant("tmo");
        for (int k = 0; k < int'(TMO); k++) begin
            check("tmo_mem_rd_held", 32'(mem_rd), 32'h1);
            check("tmo_err_low", 32'(err), 32'h0);
            check("tmo_no_done", 32'(d_done), 32'h0);
            @(negedge clk);
        end
        check("tmo_err_set", 32'(err), 32'h1);
        check("tmo_mem_rd_drop", 32'(mem_rd), 32'h0);
        check("tmo_idle", 32'(busy), 32'h0);
        check("tmo_no_done_exit", 32'(d_done), 32'h0);
        d_rd = 1'b0;
        @(negedge clk);
        check("tmo_err_sticky", 32'(err), 32'h1);

        // Reset clears err; then D read+write conflict with a pending fetch.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("err_cleared", 32'(err), 32'h0);
        d_rd   = 1'b1;
        d_wr   = 1'b1;
        d_addr = 16'h0600;
        i_rd   = 1'b1;
        i_addr = 16'h0400;
        push_exp(1'b0, 16'hCAFE);
        @(negedge clk);
        check("conf_err", 32'(err), 32'h1);
        check("conf_i_granted", 32'({mem_rd, mem_wr}), 32'h2);
        check("conf_addr", 32'(mem_addr), 32'h0400);
        serve("conf_i", 16'h0400, 16'h0000, 1'b0, 0, 16'hCAFE);
        expect_done("conf_i");
        i_rd = 1'b0;
        d_rd = 1'b0;
        d_wr = 1'b0;
        after_done("conf_i");
        check("conf_no_d_data", 32'(d_rdata), 32'h0);
        check("conf_err_sticky", 32'(err), 32'h1);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
